// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, defaults and the load-buffer entry layout for the
// register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam int PPP_W      = 3;
  localparam int WW_W       = 2;
  localparam int NUM_REGS   = 32;
  localparam int LDQ_DEPTH  = 4;
  localparam logic [WW_W-1:0] WW_DEFAULT = 2'b11;

  // Occupancy counter must represent 0..LDQ_DEPTH inclusive.
  localparam int LDQ_CNT_W  = $clog2(LDQ_DEPTH + 1);

  // One buffered load return: destination, payload and its attributes.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [PPP_W-1:0]      ppp;
    logic [WW_W-1:0]       ww;
  } wb_entry_t;

  localparam int WB_ENTRY_W = REG_ADDR_W + DATA_W + PPP_W + WW_W;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO used as the load-return buffer. Push is ignored
// when full and pop when empty; the head is visible combinationally.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted push only.
  // NOTE: the array has no reset; pointers and count alone define which
  // slots are valid, so stale contents are never presented as data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU writebacks win, buffered load
// returns drain when the ALU is idle, and a pending-load scoreboard
// drives the decode hazard signal.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_wb_valid,
  input  logic [REG_ADDR_W-1:0] alu_wb_addr,
  input  logic [DATA_W-1:0]     alu_wb_data,
  input  logic [PPP_W-1:0]      alu_wb_ppp,
  input  logic [WW_W-1:0]       alu_wb_ww,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic [PPP_W-1:0]      ld_ppp,
  input  logic [WW_W-1:0]       ld_ww,
  output logic                  ld_ready,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_addr,
  input  logic                  q_valid,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  hazard,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]     rf_din,
  output logic [PPP_W-1:0]      rf_ppp,
  output logic [WW_W-1:0]       rf_ww,
  output logic [LDQ_CNT_W-1:0]  fifo_count
);

  wb_entry_t             ld_entry;
  wb_entry_t             head;
  logic [WB_ENTRY_W-1:0] head_bits;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;

  assign ld_entry = '{addr: ld_addr, data: ld_data, ppp: ld_ppp, ww: ld_ww};
  assign head     = wb_entry_t'(head_bits);
  assign ld_ready = !fifo_full;
  assign push     = ld_valid && ld_ready;
  // The ALU pipe cannot stall, so the buffer drains only in its idle cycles.
  assign pop      = !alu_wb_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH (LDQ_DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_wb_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ld_entry),
    .pop   (pop),
    .dout  (head_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next scoreboard state: clear on pop first so an issue to the same
  // register in the same cycle overrides it.
  // NOTE: start from a full default so no path leaves pending_nxt unassigned
  // (which would infer a latch).
  always_comb begin
    pending_nxt = pending;
    if (pop)      pending_nxt[head.addr]     = 1'b0;
    if (ld_issue) pending_nxt[ld_issue_addr] = 1'b1;
  end

  // Pending-load scoreboard register.
  always_ff @(posedge clk) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign hazard = q_valid &&
                  (pending[q_rs1] || pending[q_rs2] || pending[q_rd]);

  // Registered write port: ALU first, then buffered load, else idle with
  // address/data/attributes held at their last value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_din        <= '0;
      rf_ppp        <= '0;
      rf_ww         <= WW_DEFAULT;
    end else if (alu_wb_valid) begin
      rf_write_en   <= 1'b1;
      rf_write_addr <= alu_wb_addr;
      rf_din        <= alu_wb_data;
      rf_ppp        <= alu_wb_ppp;
      rf_ww         <= alu_wb_ww;
    end else if (pop) begin
      rf_write_en   <= 1'b1;
      rf_write_addr <= head.addr;
      rf_din        <= head.data;
      rf_ppp        <= head.ppp;
      rf_ww         <= head.ww;
    end else begin
      rf_write_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a directed vector table, directed
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  alu_wb_valid;
  logic [REG_ADDR_W-1:0] alu_wb_addr;
  logic [DATA_W-1:0]     alu_wb_data;
  logic [PPP_W-1:0]      alu_wb_ppp;
  logic [WW_W-1:0]       alu_wb_ww;
  logic                  ld_valid;
  logic [REG_ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0]     ld_data;
  logic [PPP_W-1:0]      ld_ppp;
  logic [WW_W-1:0]       ld_ww;
  logic                  ld_ready;
  logic                  ld_issue;
  logic [REG_ADDR_W-1:0] ld_issue_addr;
  logic                  q_valid;
  logic [REG_ADDR_W-1:0] q_rs1;
  logic [REG_ADDR_W-1:0] q_rs2;
  logic [REG_ADDR_W-1:0] q_rd;
  logic                  hazard;
  logic                  rf_write_en;
  logic [REG_ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0]     rf_din;
  logic [PPP_W-1:0]      rf_ppp;
  logic [WW_W-1:0]       rf_ww;
  logic [LDQ_CNT_W-1:0]  fifo_count;

  rf_wb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_addr   (alu_wb_addr),
    .alu_wb_data   (alu_wb_data),
    .alu_wb_ppp    (alu_wb_ppp),
    .alu_wb_ww     (alu_wb_ww),
    .ld_valid      (ld_valid),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_ppp        (ld_ppp),
    .ld_ww         (ld_ww),
    .ld_ready      (ld_ready),
    .ld_issue      (ld_issue),
    .ld_issue_addr (ld_issue_addr),
    .q_valid       (q_valid),
    .q_rs1         (q_rs1),
    .q_rs2         (q_rs2),
    .q_rd          (q_rd),
    .hazard        (hazard),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_din        (rf_din),
    .rf_ppp        (rf_ppp),
    .rf_ww         (rf_ww),
    .fifo_count    (fifo_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  wb_entry_t             mq[$];
  logic [NUM_REGS-1:0]   m_pend = '0;
  logic                  m_en;
  logic [REG_ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0]     m_din;
  logic [PPP_W-1:0]      m_ppp;
  logic [WW_W-1:0]       m_ww;

  function automatic logic m_hazard();
    return q_valid && (m_pend[q_rs1] || m_pend[q_rs2] || m_pend[q_rd]);
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    wb_entry_t e;
    logic      accept;
    if (!reset) begin
      mq.delete();
      m_pend = '0;
      m_en = 1'b0; m_addr = '0; m_din = '0; m_ppp = '0; m_ww = WW_DEFAULT;
    end else begin
      accept = ld_valid && (mq.size() < LDQ_DEPTH);
      if (alu_wb_valid) begin
        m_en = 1'b1; m_addr = alu_wb_addr; m_din = alu_wb_data;
        m_ppp = alu_wb_ppp; m_ww = alu_wb_ww;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_en = 1'b1; m_addr = e.addr; m_din = e.data; m_ppp = e.ppp; m_ww = e.ww;
        m_pend[e.addr] = 1'b0;
      end else begin
        m_en = 1'b0;
      end
      if (ld_issue) m_pend[ld_issue_addr] = 1'b1;
      if (accept) mq.push_back('{ld_addr, ld_data, ld_ppp, ld_ww});
    end
  endtask

  // One clock: check combinational outputs, take the edge, check registers.
  // Called at the falling edge with inputs already set; returns at the next.
  task automatic tick();
    #1;
    check("ld_ready", 64'(ld_ready), 64'(mq.size() < LDQ_DEPTH));
    check("hazard", 64'(hazard), 64'(m_hazard()));
    @(posedge clk);
    model_edge();
    #1;
    check("rf_write_en", 64'(rf_write_en), 64'(m_en));
    check("rf_write_addr", 64'(rf_write_addr), 64'(m_addr));
    check("rf_din", rf_din, m_din);
    check("rf_ppp", 64'(rf_ppp), 64'(m_ppp));
    check("rf_ww", 64'(rf_ww), 64'(m_ww));
    check("fifo_count", 64'(fifo_count), 64'(mq.size()));
    @(negedge clk);
  endtask

  task automatic expect_hazard(input string name, input logic exp);
    #1;
    check(name, 64'(hazard), 64'(exp));
  endtask

  task automatic set_idle();
    alu_wb_valid = 1'b0; alu_wb_addr = '0; alu_wb_data = '0; alu_wb_ppp = '0; alu_wb_ww = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_ppp = '0; ld_ww = '0;
    ld_issue = 1'b0; ld_issue_addr = '0;
    q_valid = 1'b0; q_rs1 = '0; q_rs2 = '0; q_rd = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic                  alu_v;
    logic [REG_ADDR_W-1:0] alu_a;
    logic [DATA_W-1:0]     alu_d;
    logic [PPP_W-1:0]      alu_p;
    logic [WW_W-1:0]       alu_w;
    logic                  ld_v;
    logic [REG_ADDR_W-1:0] ld_a;
    logic [DATA_W-1:0]     ld_d;
    logic [PPP_W-1:0]      ld_p;
    logic [WW_W-1:0]       ld_w;
    logic                  e_en;
    logic [REG_ADDR_W-1:0] e_a;
    logic [DATA_W-1:0]     e_d;
    logic [PPP_W-1:0]      e_p;
    logic [WW_W-1:0]       e_w;
    logic [LDQ_CNT_W-1:0]  e_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [REG_ADDR_W-1:0] la[5];
    int  k;
    logic acc;

    // ALU-only write, hold when idle, load with no bypass, PPP/WW passthrough,
    // ALU priority over a simultaneous load, push+pop leaves count unchanged.
    vecs[0] = '{1'b1, 5'd5, 64'h8000_0000_0000_0001, 3'd0, 2'd3,  1'b0, 5'd0, 64'h0, 3'd0, 2'd0,
                1'b1, 5'd5, 64'h8000_0000_0000_0001, 3'd0, 2'd3, 3'd0};
    vecs[1] = '{1'b0, 5'd0, 64'h0, 3'd0, 2'd0,  1'b0, 5'd0, 64'h0, 3'd0, 2'd0,
                1'b0, 5'd5, 64'h8000_0000_0000_0001, 3'd0, 2'd3, 3'd0};
    vecs[2] = '{1'b0, 5'd0, 64'h0, 3'd0, 2'd0,  1'b1, 5'd9, 64'h1234, 3'b101, 2'b01,
                1'b0, 5'd5, 64'h8000_0000_0000_0001, 3'd0, 2'd3, 3'd1};
    vecs[3] = '{1'b0, 5'd0, 64'h0, 3'd0, 2'd0,  1'b0, 5'd0, 64'h0, 3'd0, 2'd0,
                1'b1, 5'd9, 64'h1234, 3'b101, 2'b01, 3'd0};
    vecs[4] = '{1'b1, 5'd0, 64'h0, 3'd7, 2'd0,  1'b1, 5'd1, 64'hAA, 3'd2, 2'd2,
                1'b1, 5'd0, 64'h0, 3'd7, 2'd0, 3'd1};
    vecs[5] = '{1'b0, 5'd0, 64'h0, 3'd0, 2'd0,  1'b1, 5'd2, 64'hBB, 3'd1, 2'd1,
                1'b1, 5'd1, 64'hAA, 3'd2, 2'd2, 3'd1};
    vecs[6] = '{1'b0, 5'd0, 64'h0, 3'd0, 2'd0,  1'b0, 5'd0, 64'h0, 3'd0, 2'd0,
                1'b1, 5'd2, 64'hBB, 3'd1, 2'd1, 3'd0};
    vecs[7] = '{1'b0, 5'd0, 64'h0, 3'd0, 2'd0,  1'b0, 5'd0, 64'h0, 3'd0, 2'd0,
                1'b0, 5'd2, 64'hBB, 3'd1, 2'd1, 3'd0};

    // ---- power-on reset ----
    set_idle();
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("rst_write_en", 64'(rf_write_en), 64'd0);
    check("rst_write_addr", 64'(rf_write_addr), 64'd0);
    check("rst_din", rf_din, 64'd0);
    check("rst_ppp", 64'(rf_ppp), 64'd0);
    check("rst_ww", 64'(rf_ww), 64'd3);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    reset = 1'b1;
    q_valid = 1'b1;
    expect_hazard("rel_hazard", 1'b0);
    check("rel_ld_ready", 64'(ld_ready), 64'd1);
    q_valid = 1'b0;

    // ---- vector table ----
    for (int i = 0; i < 8; i++) begin
      alu_wb_valid = vecs[i].alu_v; alu_wb_addr = vecs[i].alu_a; alu_wb_data = vecs[i].alu_d;
      alu_wb_ppp = vecs[i].alu_p; alu_wb_ww = vecs[i].alu_w;
      ld_valid = vecs[i].ld_v; ld_addr = vecs[i].ld_a; ld_data = vecs[i].ld_d;
      ld_ppp = vecs[i].ld_p; ld_ww = vecs[i].ld_w;
      tick();
      check($sformatf("vec%0d.en", i), 64'(rf_write_en), 64'(vecs[i].e_en));
      check($sformatf("vec%0d.addr", i), 64'(rf_write_addr), 64'(vecs[i].e_a));
      check($sformatf("vec%0d.din", i), rf_din, vecs[i].e_d);
      check($sformatf("vec%0d.ppp", i), 64'(rf_ppp), 64'(vecs[i].e_p));
      check($sformatf("vec%0d.ww", i), 64'(rf_ww), 64'(vecs[i].e_w));
      check($sformatf("vec%0d.count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
    end
    set_idle();

    // ---- contention: ALU busy 6 cycles while 5 loads arrive ----
    la[0] = 5'd10; la[1] = 5'd11; la[2] = 5'd12; la[3] = 5'd13; la[4] = 5'd14;
    k = 0;
    for (int c = 0; c < 13; c++) begin
      alu_wb_valid = (c < 6);
      alu_wb_addr  = 5'(20 + c);
      alu_wb_data  = 64'hA000 + 64'(c);
      alu_wb_ppp   = 3'(c);
      alu_wb_ww    = 2'(c);
      ld_valid     = (k < 5);
      if (k < 5) begin
        ld_addr = la[k]; ld_data = 64'hD000 + 64'(k); ld_ppp = 3'(k); ld_ww = 2'(k);
      end
      if (c == 4) begin
        #1;
        check("cont_ready_full", 64'(ld_ready), 64'd0);
        check("cont_count_full", 64'(fifo_count), 64'd4);
      end
      if (c == 7) begin
        #1;
        check("cont_ready_after_pop", 64'(ld_ready), 64'd1);
      end
      acc = ld_valid && (mq.size() < LDQ_DEPTH);
      tick();
      if (acc) k++;
      if (c >= 6 && c <= 10) begin
        check($sformatf("cont_wr_en%0d", c - 6), 64'(rf_write_en), 64'd1);
        check($sformatf("cont_wr_addr%0d", c - 6), 64'(rf_write_addr), 64'(la[c - 6]));
        check($sformatf("cont_wr_data%0d", c - 6), rf_din, 64'hD000 + 64'(c - 6));
      end
    end
    set_idle();

    // ---- scoreboard: hazard on r7 until its load pops ----
    q_valid = 1'b1; q_rs1 = 5'd7;
    ld_issue = 1'b1; ld_issue_addr = 5'd7;
    expect_hazard("sb_before_issue", 1'b0);
    tick();
    ld_issue = 1'b0;
    expect_hazard("sb_pending", 1'b1);
    tick();
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 64'h77; ld_ppp = 3'd0; ld_ww = 2'd0;
    expect_hazard("sb_load_arrives", 1'b1);
    tick();
    ld_valid = 1'b0;
    expect_hazard("sb_pop_cycle", 1'b1);
    tick();
    check("sb_write_r7", 64'(rf_write_addr), 64'd7);
    expect_hazard("sb_cleared", 1'b0);
    tick();
    set_idle();

    // ---- simultaneous set/clear of r3: set wins ----
    q_valid = 1'b1; q_rd = 5'd3;
    ld_issue = 1'b1; ld_issue_addr = 5'd3;
    tick();
    ld_issue = 1'b0;
    ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 64'h33;
    tick();
    ld_valid = 1'b0;
    ld_issue = 1'b1; ld_issue_addr = 5'd3;
    expect_hazard("sc_pop_cycle", 1'b1);
    tick();
    ld_issue = 1'b0;
    expect_hazard("sc_set_wins", 1'b1);
    tick();
    ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 64'h34;
    tick();
    ld_valid = 1'b0;
    tick();
    expect_hazard("sc_finally_clear", 1'b0);
    tick();
    set_idle();

    // ---- reset with 3 buffered entries and r2, r9 pending ----
    ld_issue = 1'b1; ld_issue_addr = 5'd2;
    tick();
    ld_issue_addr = 5'd9;
    tick();
    ld_issue = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd30; alu_wb_data = 64'hC0DE;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_addr = 5'(16 + i); ld_data = 64'hE000 + 64'(i);
      tick();
    end
    ld_valid = 1'b0;
    check("rstmid_count_before", 64'(fifo_count), 64'd3);
    q_valid = 1'b1; q_rs1 = 5'd2; q_rs2 = 5'd9; q_rd = 5'd0;
    expect_hazard("rstmid_hazard_before", 1'b1);
    alu_wb_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("rstmid_count", 64'(fifo_count), 64'd0);
    check("rstmid_write_en", 64'(rf_write_en), 64'd0);
    reset = 1'b1;
    expect_hazard("rstmid_hazard_after", 1'b0);
    check("rstmid_ld_ready", 64'(ld_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rstmid_no_stale%0d", i), 64'(rf_write_en), 64'd0);
    end
    set_idle();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 299) != 0);
      alu_wb_valid  = ($urandom_range(0, 99) < 40);
      alu_wb_addr   = 5'($urandom);
      alu_wb_data   = {$urandom, $urandom};
      alu_wb_ppp    = 3'($urandom);
      alu_wb_ww     = 2'($urandom);
      ld_valid      = ($urandom_range(0, 99) < 60);
      ld_addr       = 5'($urandom_range(0, 7));
      ld_data       = {$urandom, $urandom};
      ld_ppp        = 3'($urandom);
      ld_ww         = 2'($urandom);
      ld_issue      = ($urandom_range(0, 99) < 25);
      ld_issue_addr = 5'($urandom_range(0, 7));
      q_valid       = ($urandom_range(0, 99) < 70);
      q_rs1         = 5'($urandom_range(0, 9));
      q_rs2         = 5'($urandom_range(0, 9));
      q_rd          = 5'($urandom_range(0, 9));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
